// File: rtl/serial_add_pkg.sv
// Shared types and constants for the byte-serial adder controller.
package serial_add_pkg;

    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a lane index able to address n lanes (at least 1 bit).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_add_byte_adc.sv
// byte_adc: one byte lane of the serial adder, 8-bit add with carry-in.
// An 8-bit carry-select slice (two nibbles, upper nibble precomputed for both
// incoming carries) produces a+b; the lane carry-in then selects between that
// result and the result plus one. Purely combinational.
module byte_adc
    import serial_add_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              cin,
    output logic [LANE_W-1:0] s,
    output logic              cout
);

    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;
    logic [8:0] slice_sum;
    logic [8:0] slice_inc;

    // Carry-select slice for a+b, then the +1 select driven by cin.
    always_comb begin
        lo        = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        hi0       = {1'b0, a[7:4]} + {1'b0, b[7:4]};
        hi1       = hi0 + 5'd1;
        slice_sum = lo[4] ? {hi1, lo[3:0]} : {hi0, lo[3:0]};
        slice_inc = slice_sum + 9'd1;
        {cout, s} = cin ? slice_inc : slice_sum;
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: adds two NBYTES-wide operands one byte lane per cycle,
// LSB lane first, with the inter-lane carry held in a register.
// Optional build macro SERIAL_ADD_SUB_EN adds a `sub` input that turns the
// operation into a - b (B lanes inverted, initial carry 1).
//
// Handshake: start is a request that is taken only while busy is low (IDLE);
// a, b (and sub) are captured on that edge and later changes are ignored.
// There is no ready back-pressure on the result: done pulses for one cycle
// when sum/carry are final, and they hold until the next accepted start.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         carry
);

    localparam int            IW   = clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    state_t              state;
    state_t              state_nxt;
    logic   [IW-1:0]     idx;
    logic   [W-1:0]      a_reg;
    logic   [W-1:0]      b_reg;
    logic                c_reg;
    logic   [LANE_W-1:0] a_lane;
    logic   [LANE_W-1:0] b_lane;
    logic   [LANE_W-1:0] lane_s;
    logic                lane_c;
    logic                accept;
    logic                cin_init;

    assign accept = (state == IDLE) && start;

`ifdef SERIAL_ADD_SUB_EN
    logic sub_reg;

    // Subtract mode captured with the operands; held for the whole operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_reg <= 1'b0;
        end else if (accept) begin
            sub_reg <= sub;
        end
    end

    assign cin_init = sub;
    assign b_lane   = sub_reg ? ~b_reg[int'(idx)*LANE_W +: LANE_W]
                              :  b_reg[int'(idx)*LANE_W +: LANE_W];
`else
    assign cin_init = 1'b0;
    assign b_lane   = b_reg[int'(idx)*LANE_W +: LANE_W];
`endif

    assign a_lane = a_reg[int'(idx)*LANE_W +: LANE_W];

    byte_adc u_lane (
        .a    (a_lane),
        .b    (b_lane),
        .cin  (c_reg),
        .s    (lane_s),
        .cout (lane_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and status outputs decoded from the state.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (idx == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept, then one result lane and carry per ADD cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            carry <= 1'b0;
            c_reg <= 1'b0;
            idx   <= '0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            sum   <= '0;
            carry <= 1'b0;
            c_reg <= cin_init;
            idx   <= '0;
        end else if (state == ADD) begin
            sum[int'(idx)*LANE_W +: LANE_W] <= lane_s;
            c_reg <= lane_c;
            if (idx == LAST) begin
                carry <= lane_c;
                idx   <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and reference-model checks for serial_add_ctrl at NBYTES=4 and 2.
module tb_serial_add_ctrl;

    logic        clk;
    logic        rst_n;

    logic        start4;
    logic [31:0] a4;
    logic [31:0] b4;
    logic        sub4;
    logic        busy4;
    logic        done4;
    logic [31:0] sum4;
    logic        carry4;

    logic        start2;
    logic [15:0] a2;
    logic [15:0] b2;
    logic        sub2;
    logic        busy2;
    logic        done2;
    logic [15:0] sum2;
    logic        carry2;

    int n_cmp;
    int n_err;
    int done_cnt4;

    serial_add_ctrl #(.NBYTES(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub4),
`endif
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .carry (carry4)
    );

    serial_add_ctrl #(.NBYTES(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .a     (a2),
        .b     (b2),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub2),
`endif
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .carry (carry2)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin
        if (done4) begin
            done_cnt4 <= done_cnt4 + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: a+b, or a + ~b + 1 in subtract mode, over nb bytes.
    function automatic logic [63:0] ref_op(input int nb, input logic [31:0] av,
                                           input logic [31:0] bv, input logic sv);
        logic [63:0] mask;
        logic [63:0] t;
        mask = (64'd1 << (nb * 8)) - 64'd1;
        if (sv) begin
            t = ({32'd0, av} & mask) + (~{32'd0, bv} & mask) + 64'd1;
        end else begin
            t = ({32'd0, av} & mask) + ({32'd0, bv} & mask);
        end
        return t;
    endfunction

    // Drive one request on the chosen DUT and wait (bounded) for done.
    // edges counts rising edges from the accepting edge through the edge
    // that raises done, inclusive.
    task automatic do_op(input int which, input logic [31:0] av, input logic [31:0] bv,
                         input logic sv, output logic [31:0] s_o, output logic c_o,
                         output int edges);
        @(negedge clk);
        if (which == 4) begin
            a4 = av; b4 = bv; sub4 = sv; start4 = 1'b1;
        end else begin
            a2 = av[15:0]; b2 = bv[15:0]; sub2 = sv; start2 = 1'b1;
        end
        @(negedge clk);
        start4 = 1'b0;
        start2 = 1'b0;
        edges  = 1;
        while (!((which == 4) ? done4 : done2) && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        s_o = (which == 4) ? sum4 : {16'd0, sum2};
        c_o = (which == 4) ? carry4 : carry2;
    endtask

    task automatic wait_done4(output int edges);
        edges = 0;
        while (!done4 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
    endtask

    logic [31:0] s;
    logic        c;
    int          lat;
    int          snap;
    logic [63:0] r;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    initial begin
        n_cmp = 0; n_err = 0; done_cnt4 = 0;
        rst_n = 1'b0;
        start4 = 0; a4 = '0; b4 = '0; sub4 = 0;
        start2 = 0; a2 = '0; b2 = '0; sub2 = 0;

        repeat (3) @(negedge clk);
        check("rst_sum", {32'd0, sum4}, 64'd0);
        check("rst_carry", {63'd0, carry4}, 64'd0);
        check("rst_busy", {63'd0, busy4}, 64'd0);
        check("rst_done", {63'd0, done4}, 64'd0);
        rst_n = 1'b1;

        // 1: simple add, latency, status during and after DONE
        do_op(4, 32'h0000_0001, 32'h0000_0002, 1'b0, s, c, lat);
        check("t1_latency", 64'(lat), 64'd5);
        check("t1_sum", {32'd0, s}, 64'h0000_0003);
        check("t1_carry", {63'd0, c}, 64'd0);
        check("t1_busy_done", {63'd0, busy4}, 64'd1);
        @(negedge clk);
        check("t1_done_pulse", {63'd0, done4}, 64'd0);
        check("t1_busy_idle", {63'd0, busy4}, 64'd0);
        check("t1_sum_hold", {32'd0, sum4}, 64'h0000_0003);

        // 2: carry ripples through every lane
        do_op(4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, s, c, lat);
        check("t2_sum", {32'd0, s}, 64'h0000_0000);
        check("t2_carry", {63'd0, c}, 64'd1);

        // 6a: back-to-back, start in the cycle right after DONE
        do_op(4, 32'h1234_5678, 32'h1111_1111, 1'b0, s, c, lat);
        check("b2b_latency", 64'(lat), 64'd5);
        check("b2b_sum", {32'd0, s}, 64'h2345_6789);
        check("b2b_carry", {63'd0, c}, 64'd0);

        // 3: start re-pulsed mid-operation with other operands is ignored
        @(negedge clk);
        snap = done_cnt4;
        a4 = 32'h00FF_00FF; b4 = 32'h0001_0001; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        a4 = 32'hFFFF_FFFF; b4 = 32'hFFFF_FFFF; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4(lat);
        check("t3_done_seen", {63'd0, done4}, 64'd1);
        check("t3_sum", {32'd0, sum4}, 64'h0100_0100);
        check("t3_carry", {63'd0, carry4}, 64'd0);
        repeat (8) @(negedge clk);
        check("t3_single_done", 64'(done_cnt4 - snap), 64'd1);
        check("t3_idle", {63'd0, busy4}, 64'd0);

        // 4: reset in the middle of an add
        @(negedge clk);
        a4 = 32'h0F0F_0F0F; b4 = 32'h0101_0101; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t4_busy", {63'd0, busy4}, 64'd0);
        check("t4_sum", {32'd0, sum4}, 64'd0);
        check("t4_carry", {63'd0, carry4}, 64'd0);
        check("t4_done", {63'd0, done4}, 64'd0);
        snap = done_cnt4;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("t4_no_done", 64'(done_cnt4 - snap), 64'd0);
        do_op(4, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, s, c, lat);
        check("t4_after_sum", {32'd0, s}, 64'h1010_1010);
        check("t4_after_carry", {63'd0, c}, 64'd0);

        // NBYTES=2 directed corner
        do_op(2, 32'h0000_FFFF, 32'h0000_0001, 1'b0, s, c, lat);
        check("n2_latency", 64'(lat), 64'd3);
        check("n2_sum", {32'd0, s}, 64'h0000_0000);
        check("n2_carry", {63'd0, c}, 64'd1);

`ifdef SERIAL_ADD_SUB_EN
        // 5: subtract mode
        do_op(4, 32'd5, 32'd7, 1'b1, s, c, lat);
        check("t5_sub_sum", {32'd0, s}, 64'hFFFF_FFFE);
        check("t5_sub_carry", {63'd0, c}, 64'd0);
        do_op(4, 32'd7, 32'd5, 1'b1, s, c, lat);
        check("t5_sub2_sum", {32'd0, s}, 64'h0000_0002);
        check("t5_sub2_carry", {63'd0, c}, 64'd1);
`endif

        // 6b: random operands against the reference, both widths
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom;
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            r = ref_op(4, ra, rb, rs);
            do_op(4, ra, rb, rs, s, c, lat);
            check("rnd4_sum", {32'd0, s}, {32'd0, r[31:0]});
            check("rnd4_carry", {63'd0, c}, {63'd0, r[32]});

            ra = 32'($urandom_range(0, 65535));
            rb = 32'($urandom_range(0, 65535));
            r = ref_op(2, ra, rb, rs);
            do_op(2, ra, rb, rs, s, c, lat);
            check("rnd2_sum", {32'd0, s}, {48'd0, r[15:0]});
            check("rnd2_carry", {63'd0, c}, {63'd0, r[16]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
